// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host receiver with input filtering, frame checks and watchdog.
// Define PS2_PREFIX_DECODE_EN to fold E0/F0 prefixes into is_ext/is_break.
module ps2_rx #(
    parameter int CLOCK_FREQUENCY = 200000000,
    parameter int FILTER_LEN      = 16,
    parameter int TIMEOUT_US      = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] dout,
    output logic       dout_valid,
    output logic       is_break,
    output logic       is_ext,
    output logic       frame_err
);
    localparam int TIMEOUT_CYC = CLOCK_FREQUENCY / 1000000 * TIMEOUT_US;
    localparam int WD_W        = $clog2(TIMEOUT_CYC + 1);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;
    // Bit 0 carries the PS/2 clock, bit 1 the PS/2 data.
    logic [1:0] s1_q, s2_q, f_q;
    logic [7:0] cnt_q [2];
    logic fprev_q, fall_q, din;
    state_e state_q;
    logic [2:0] bitcnt_q;
    logic [7:0] sh_q, dout_q;
    logic perr_q, valid_q, err_q;
    logic [WD_W-1:0] wd_q, wd_d;
    logic timeout, stop_evt, accept, err_d, valid_d;
    assign din = f_q[1];
    assign wd_d = wd_q + 1'b1;
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= 2'b11;
            s2_q    <= 2'b11;
            f_q     <= 2'b11;
            cnt_q   <= '{default: '0};
            fprev_q <= 1'b1;
            fall_q  <= 1'b0;
        end else begin
            s1_q    <= {ps2_data, ps2_clk};
            s2_q    <= s1_q;
            for (int i = 0; i < 2; i++) begin
                if (s2_q[i] == f_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == 8'(FILTER_LEN - 1)) begin
                    f_q[i]   <= s2_q[i];
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 8'd1;
                end
            end
            fprev_q <= f_q[0];
            fall_q  <= fprev_q & ~f_q[0];
        end
    end
    // The watchdog fires on the edge where the counter would reach TIMEOUT_CYC-1.
    assign timeout  = state_q != IDLE && !fall_q && wd_d == WD_W'(TIMEOUT_CYC - 1);
    assign stop_evt = fall_q && state_q == STOP;
    assign accept   = stop_evt && din && !perr_q;
    assign err_d    = timeout || (fall_q && state_q == IDLE && din) || (stop_evt && !accept);
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            bitcnt_q <= '0;
            sh_q     <= '0;
            perr_q   <= 1'b0;
            wd_q     <= '0;
        end else begin
            wd_q <= (state_q == IDLE || fall_q || timeout) ? '0 : wd_d;
            if (timeout) begin
                state_q <= IDLE;
            end else if (fall_q) begin
                case (state_q)
                    IDLE: begin
                        state_q  <= din ? IDLE : DATA;
                        bitcnt_q <= '0;
                    end
                    DATA: begin
                        sh_q     <= {din, sh_q[7:1]};
                        bitcnt_q <= bitcnt_q + 3'd1;
                        state_q  <= bitcnt_q == 3'd7 ? PARITY : DATA;
                    end
                    PARITY: begin
                        perr_q  <= ~(^sh_q ^ din);
                        state_q <= STOP;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
`ifdef PS2_PREFIX_DECODE_EN
    logic ext_pend_q, brk_pend_q, is_ext_q, is_brk_q, is_pfx;
    assign is_pfx  = sh_q == 8'hE0 || sh_q == 8'hF0;
    assign valid_d = accept && !is_pfx;
    always_ff @(posedge clk) begin
        if (rst || err_d) begin
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
        end else if (accept) begin
            ext_pend_q <= is_pfx && (ext_pend_q || sh_q == 8'hE0);
            brk_pend_q <= is_pfx && (brk_pend_q || sh_q == 8'hF0);
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            is_ext_q <= 1'b0;
            is_brk_q <= 1'b0;
        end else if (valid_d) begin
            is_ext_q <= ext_pend_q;
            is_brk_q <= brk_pend_q;
        end
    end
    assign is_ext   = is_ext_q;
    assign is_break = is_brk_q;
`else
    assign valid_d  = accept;
    assign is_ext   = 1'b0;
    assign is_break = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            dout_q  <= valid_d ? sh_q : dout_q;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end
    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign frame_err  = err_q;
endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: directed bench for ps2_rx at 1 MHz, FILTER_LEN=4, 200 us timeout, 50 us PS/2 bit period.
// Expectations follow PS2_PREFIX_DECODE_EN when the bench is built with it defined.
`timescale 1ns/1ps
module tb_ps2_rx;
    logic clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
    logic [7:0] dout;
    logic dout_valid, is_break, is_ext, frame_err;
    int n_chk = 0, n_fail = 0, cyc = 0, last_fall = 0, err_cyc = 0, n_err = 0, n_fall = 0, n_both = 0, f0;
    logic [9:0] cap_q[$], exp_q[$];

    ps2_rx #(.CLOCK_FREQUENCY(1000000), .FILTER_LEN(4), .TIMEOUT_US(200)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .dout(dout), .dout_valid(dout_valid), .is_break(is_break), .is_ext(is_ext),
        .frame_err(frame_err)
    );

    always #500 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dut.fall_q) begin
            last_fall = cyc;
            n_fall++;
        end
        if (dout_valid) cap_q.push_back({is_ext, is_break, dout});
        if (frame_err) begin
            n_err++;
            err_cyc = cyc;
        end
        if (dout_valid && frame_err) n_both++;
    end

    initial begin
        #50_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "tb_ps2_rx timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Compares captured {ext,brk,dout} words against the expected list, then empties both.
    task automatic chk_caps(input string tag);
        chk({tag, "_count"}, cap_q.size(), exp_q.size());
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_cap%0d", tag, i), cap_q[i], exp_q[i]);
        cap_q.delete();
        exp_q.delete();
    endtask

    function automatic logic [10:0] frame(input logic [7:0] b, input logic bad_par);
        return {1'b1, ~^b ^ bad_par, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] fr, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = fr[i];
            repeat (25) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (25) @(negedge clk);
            ps2_clk = 1'b1;
        end
        repeat (25) @(negedge clk);
        ps2_data = 1'b1;
        repeat (25) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic bad_par);
        send_bits(frame(b, bad_par), 11);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_dout", dout, 8'h00);
        chk("rst_valid", dout_valid, 1'b0);
        chk("rst_brk", is_break, 1'b0);
        chk("rst_ext", is_ext, 1'b0);
        chk("rst_err", frame_err, 1'b0);

        send(8'h1C, 1'b0);
        exp_q.push_back(10'h01C);
        chk_caps("t1");
        chk("t1_err", n_err, 0);

        send(8'hF0, 1'b0);
        send(8'h1C, 1'b0);
        send(8'hE0, 1'b0);
        send(8'hF0, 1'b0);
        send(8'h74, 1'b0);
`ifdef PS2_PREFIX_DECODE_EN
        exp_q.push_back(10'h11C);
        exp_q.push_back(10'h374);
`else
        exp_q.push_back(10'h0F0);
        exp_q.push_back(10'h01C);
        exp_q.push_back(10'h0E0);
        exp_q.push_back(10'h0F0);
        exp_q.push_back(10'h074);
`endif
        chk_caps("t2");
        chk("t2_err", n_err, 0);

        // A pending break must be dropped by the parity error that follows it.
        send(8'hF0, 1'b0);
`ifndef PS2_PREFIX_DECODE_EN
        exp_q.push_back(10'h0F0);
`endif
        chk_caps("t3_pfx");
        send(8'h1C, 1'b1);
        chk("par_err_cnt", n_err, 1);
        chk("par_err_lat", err_cyc - last_fall, 1);
        chk_caps("par_no_valid");
        send(8'h2A, 1'b0);
        exp_q.push_back(10'h02A);
        chk_caps("t3_good");
        chk("t3_err_total", n_err, 1);

        n_err = 0;
        f0 = n_fall;
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (20) @(negedge clk);
        chk("glitch_fall", n_fall - f0, 0);
        send(8'h5A, 1'b0);
        exp_q.push_back(10'h05A);
        chk_caps("t4");
        chk("t4_err", n_err, 0);

        send_bits(frame(8'h45, 1'b0), 6);
        repeat (300) @(negedge clk);
        chk("to_err_cnt", n_err, 1);
        chk("to_err_lat", err_cyc - last_fall, 200);
        chk_caps("to_no_valid");
        n_err = 0;
        send(8'h45, 1'b0);
        exp_q.push_back(10'h045);
        chk_caps("t5");
        chk("t5_err", n_err, 0);

        // Reset mid-frame must also drop a pending break.
        send(8'hF0, 1'b0);
        send_bits(frame(8'h1C, 1'b0), 4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_dout", dout, 8'h00);
        chk("mrst_valid", dout_valid, 1'b0);
        chk("mrst_brk", is_break, 1'b0);
        chk("mrst_ext", is_ext, 1'b0);
        chk("mrst_err", frame_err, 1'b0);
        repeat (300) @(negedge clk);
        chk("mrst_no_err", n_err, 0);
`ifndef PS2_PREFIX_DECODE_EN
        exp_q.push_back(10'h0F0);
`endif
        chk_caps("t6_pre");
        send(8'h1C, 1'b0);
        exp_q.push_back(10'h01C);
        chk_caps("t6_post");
        chk("no_overlap", n_both, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
